traffic_phase_ctrl: RTL and testbench

Phase sequencer for a four-way intersection. It drives a North/South axis and an East/West axis through green, left-turn, yellow and all-red phases. Pedestrian walk phases are granted only on request, and an emergency-vehicle input can pre-empt the normal sequence. It replaces the free-running cycle counter as the single source of signal-head codes: one instance per intersection, with its outputs fanned out to the N/S/E/W heads.

---
 rtl/traffic_phase_ctrl.sv | 219 +++++++++++++++++++++
 tb/tb_traffic_phase_ctrl.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/traffic_phase_ctrl.sv
// Four-way intersection phase sequencer: N/S and E/W car heads, on-demand
// pedestrian walk phases and emergency-vehicle pre-emption.
module traffic_phase_ctrl #(
   parameter int T_GREEN  = 20,
   parameter int T_LEFT   = 10,
   parameter int T_YELLOW = 2,
   parameter int T_ALLRED = 1,
   parameter int T_WALK   = 14,
   parameter int T_FLASH  = 6
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       i_start,
   input  logic       i_ped_req_ns,
   input  logic       i_ped_req_ew,
   input  logic       i_emg,
   input  logic       i_emg_dir,
   output logic [1:0] o_car_ns,
   output logic [1:0] o_car_ew,
   output logic [1:0] o_ped_ns,
   output logic [1:0] o_ped_ew,
   output logic [3:0] o_state,
   output logic [5:0] o_timer
);

   typedef enum logic [3:0] {
      IDLE    = 4'd0,
      NS_GO   = 4'd1,
      NS_LEFT = 4'd2,
      NS_YEL  = 4'd3,
      AR_NS   = 4'd4,
      EW_GO   = 4'd5,
      EW_LEFT = 4'd6,
      EW_YEL  = 4'd7,
      AR_EW   = 4'd8,
      PRE_NS  = 4'd9,
      PRE_EW  = 4'd10
   } state_t;

   localparam logic [5:0] LD_GREEN  = 6'(T_GREEN - 1);
   localparam logic [5:0] LD_LEFT   = 6'(T_LEFT - 1);
   localparam logic [5:0] LD_YELLOW = 6'(T_YELLOW - 1);
   localparam logic [5:0] LD_ALLRED = 6'(T_ALLRED - 1);
   localparam logic [6:0] GREEN_M1  = 7'(T_GREEN - 1);
   localparam logic [6:0] WALK_END  = 7'(T_WALK);
   localparam logic [6:0] FLASH_END = 7'(T_WALK + T_FLASH);

   localparam logic [1:0] CAR_RED  = 2'b00;
   localparam logic [1:0] CAR_GRN  = 2'b01;
   localparam logic [1:0] CAR_YEL  = 2'b10;
   localparam logic [1:0] CAR_LEFT = 2'b11;

   state_t     state, state_n;
   logic [5:0] timer, timer_n;
   logic       pend_ns, pend_ew;
   logic       serve_ns, serve_ns_n;
   logic       serve_ew, serve_ew_n;
   logic       clr_pend_ns, clr_pend_ew;
   logic       tmo;

   // Walk for T_WALK cycles of green, then flash (walk on even offsets), then don't-walk.
   function automatic logic [1:0] ped_code(input logic serve, input logic [5:0] tmr);
      logic [6:0] elapsed;
      logic [6:0] ofs;
      elapsed = GREEN_M1 - {1'b0, tmr};
      ofs     = elapsed - WALK_END;
      if (!serve)                 ped_code = 2'b00;
      else if (elapsed < WALK_END)  ped_code = 2'b01;
      else if (elapsed < FLASH_END) ped_code = ofs[0] ? 2'b00 : 2'b01;
      else                        ped_code = 2'b00;
   endfunction

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= IDLE;
         timer    <= 6'd0;
         pend_ns  <= 1'b0;
         pend_ew  <= 1'b0;
         serve_ns <= 1'b0;
         serve_ew <= 1'b0;
      end else begin
         state    <= state_n;
         timer    <= timer_n;
         serve_ns <= serve_ns_n;
         serve_ew <= serve_ew_n;
         // A press on the entry edge itself wins over the clear and waits for the next green.
         pend_ns  <= (pend_ns & ~clr_pend_ns) | i_ped_req_ns;
         pend_ew  <= (pend_ew & ~clr_pend_ew) | i_ped_req_ew;
      end
   end

   assign tmo = (timer == 6'd0);

   always_comb begin
      state_n     = state;
      timer_n     = timer;
      serve_ns_n  = serve_ns;
      serve_ew_n  = serve_ew;
      clr_pend_ns = 1'b0;
      clr_pend_ew = 1'b0;
      case (state)
         IDLE: begin
            if (i_start) begin
               state_n     = NS_GO;
               timer_n     = LD_GREEN;
               serve_ew_n  = pend_ew;
               clr_pend_ew = pend_ew;
            end
         end
         NS_GO, NS_LEFT: begin
            if (i_start) begin
               if (i_emg && !i_emg_dir) begin
                  state_n = PRE_NS;
                  timer_n = 6'd0;
               end else if (i_emg) begin
                  state_n = NS_YEL;
                  timer_n = LD_YELLOW;
               end else if (tmo && state == NS_GO) begin
                  state_n = NS_LEFT;
                  timer_n = LD_LEFT;
               end else if (tmo) begin
                  state_n = NS_YEL;
                  timer_n = LD_YELLOW;
               end else begin
                  timer_n = timer - 6'd1;
               end
            end
         end
         EW_GO, EW_LEFT: begin
            if (i_start) begin
               if (i_emg && i_emg_dir) begin
                  state_n = PRE_EW;
                  timer_n = 6'd0;
               end else if (i_emg) begin
                  state_n = EW_YEL;
                  timer_n = LD_YELLOW;
               end else if (tmo && state == EW_GO) begin
                  state_n = EW_LEFT;
                  timer_n = LD_LEFT;
               end else if (tmo) begin
                  state_n = EW_YEL;
                  timer_n = LD_YELLOW;
               end else begin
                  timer_n = timer - 6'd1;
               end
            end
         end
         NS_YEL, EW_YEL: begin
            if (i_start) begin
               if (tmo) begin
                  state_n = (state == NS_YEL) ? AR_NS : AR_EW;
                  timer_n = LD_ALLRED;
               end else begin
                  timer_n = timer - 6'd1;
               end
            end
         end
         AR_NS, AR_EW: begin
            if (i_start) begin
               if (tmo && i_emg) begin
                  state_n = i_emg_dir ? PRE_EW : PRE_NS;
                  timer_n = 6'd0;
               end else if (tmo && state == AR_NS) begin
                  state_n     = EW_GO;
                  timer_n     = LD_GREEN;
                  serve_ns_n  = pend_ns;
                  clr_pend_ns = pend_ns;
               end else if (tmo) begin
                  state_n     = NS_GO;
                  timer_n     = LD_GREEN;
                  serve_ew_n  = pend_ew;
                  clr_pend_ew = pend_ew;
               end else begin
                  timer_n = timer - 6'd1;
               end
            end
         end
         PRE_NS: begin
            if (i_start && (!i_emg || i_emg_dir)) begin
               state_n = NS_YEL;
               timer_n = LD_YELLOW;
            end
         end
         PRE_EW: begin
            if (i_start && (!i_emg || !i_emg_dir)) begin
               state_n = EW_YEL;
               timer_n = LD_YELLOW;
            end
         end
         default: begin
            state_n = IDLE;
            timer_n = 6'd0;
         end
      endcase
      // Any way out of a green ends that crosswalk's service.
      if (state_n != NS_GO) serve_ew_n = 1'b0;
      if (state_n != EW_GO) serve_ns_n = 1'b0;
   end

   always_comb begin
      o_car_ns = CAR_RED;
      o_car_ew = CAR_RED;
      case (state)
         NS_GO, PRE_NS: o_car_ns = CAR_GRN;
         NS_LEFT:       o_car_ns = CAR_LEFT;
         NS_YEL:        o_car_ns = CAR_YEL;
         EW_GO, PRE_EW: o_car_ew = CAR_GRN;
         EW_LEFT:       o_car_ew = CAR_LEFT;
         EW_YEL:        o_car_ew = CAR_YEL;
         default: ;
      endcase
   end

   assign o_ped_ns = (state == EW_GO) ? ped_code(serve_ns, timer) : 2'b00;
   assign o_ped_ew = (state == NS_GO) ? ped_code(serve_ew, timer) : 2'b00;
   assign o_state  = state;
   assign o_timer  = timer;

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Scoreboard bench for traffic_phase_ctrl: driver queues hand-computed
// expectations tagged with an edge number, monitor checks them at negedge.
module tb_traffic_phase_ctrl;

   logic       clk = 1'b0;
   logic       rst_n, i_start, i_ped_req_ns, i_ped_req_ew, i_emg, i_emg_dir;
   logic [1:0] o_car_ns, o_car_ew, o_ped_ns, o_ped_ew;
   logic [3:0] o_state;
   logic [5:0] o_timer;

   traffic_phase_ctrl dut (
      .clk(clk), .rst_n(rst_n), .i_start(i_start),
      .i_ped_req_ns(i_ped_req_ns), .i_ped_req_ew(i_ped_req_ew),
      .i_emg(i_emg), .i_emg_dir(i_emg_dir),
      .o_car_ns(o_car_ns), .o_car_ew(o_car_ew),
      .o_ped_ns(o_ped_ns), .o_ped_ew(o_ped_ew),
      .o_state(o_state), .o_timer(o_timer)
   );

   always #5 clk = ~clk;

   localparam logic [3:0] S_IDLE = 4'd0, S_NS_GO = 4'd1, S_NS_LEFT = 4'd2, S_NS_YEL = 4'd3,
                          S_AR_NS = 4'd4, S_EW_GO = 4'd5, S_EW_LEFT = 4'd6, S_EW_YEL = 4'd7,
                          S_AR_EW = 4'd8, S_PRE_NS = 4'd9, S_PRE_EW = 4'd10;

   typedef struct {
      int          tag;
      string       name;
      logic [17:0] vec;
   } exp_t;

   exp_t q[$];
   int   cyc = 0;
   int   e0 = 0;
   int   n_chk = 0;
   int   n_err = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: compare every expectation whose edge has just passed.
   always @(negedge clk) begin
      while (q.size() > 0 && q[0].tag <= cyc) begin
         exp_t e;
         logic [17:0] act;
         e   = q.pop_front();
         act = {o_state, o_timer, o_car_ns, o_car_ew, o_ped_ns, o_ped_ew};
         n_chk++;
         if (e.tag != cyc) begin
            n_err++;
            $display("FAIL %s: stale expectation for edge %0d checked at %0d", e.name, e.tag, cyc);
         end else if (act !== e.vec) begin
            n_err++;
            $display("FAIL %s @edge %0d: got st=%0d tm=%0d car=%b/%b ped=%b/%b, want st=%0d tm=%0d car=%b/%b ped=%b/%b",
                     e.name, e.tag - e0, act[17:14], act[13:8], act[7:6], act[5:4], act[3:2], act[1:0],
                     e.vec[17:14], e.vec[13:8], e.vec[7:6], e.vec[5:4], e.vec[3:2], e.vec[1:0]);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic push(input int tag, input string nm, input logic [3:0] st, input logic [5:0] tm,
                       input logic [1:0] cns, input logic [1:0] cew, input logic [1:0] pns, input logic [1:0] pew);
      exp_t e;
      e.tag  = tag;
      e.name = nm;
      e.vec  = {st, tm, cns, cew, pns, pew};
      q.push_back(e);
   endtask

   // Advance to just before relative edge k, queue its expectation, take the edge.
   task automatic chk_at(input int k, input string nm, input logic [3:0] st, input logic [5:0] tm,
                         input logic [1:0] cns, input logic [1:0] cew, input logic [1:0] pns, input logic [1:0] pew);
      while (cyc < e0 + k - 1) step();
      push(e0 + k, nm, st, tm, cns, cew, pns, pew);
      step();
   endtask

   task automatic do_reset(input string nm);
      rst_n = 1'b0; i_start = 1'b0; i_ped_req_ns = 1'b0; i_ped_req_ew = 1'b0;
      i_emg = 1'b0; i_emg_dir = 1'b0;
      push(cyc + 1, nm, S_IDLE, 6'd0, 2'b00, 2'b00, 2'b00, 2'b00);
      step();
      rst_n   = 1'b1;
      e0      = cyc;
      i_start = 1'b1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", n_err, n_chk);
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0; i_start = 1'b0; i_ped_req_ns = 1'b0; i_ped_req_ew = 1'b0;
      i_emg = 1'b0; i_emg_dir = 1'b0;
      @(negedge clk);

      // Normal cycle, no requests
      do_reset("reset_state");
      chk_at(1,  "norm_ns_go",    S_NS_GO,   6'd19, 2'b01, 2'b00, 2'b00, 2'b00);
      chk_at(20, "norm_ns_go_end", S_NS_GO,  6'd0,  2'b01, 2'b00, 2'b00, 2'b00);
      chk_at(21, "norm_ns_left",  S_NS_LEFT, 6'd9,  2'b11, 2'b00, 2'b00, 2'b00);
      chk_at(30, "norm_left_end", S_NS_LEFT, 6'd0,  2'b11, 2'b00, 2'b00, 2'b00);
      chk_at(31, "norm_ns_yel",   S_NS_YEL,  6'd1,  2'b10, 2'b00, 2'b00, 2'b00);
      chk_at(32, "norm_yel_end",  S_NS_YEL,  6'd0,  2'b10, 2'b00, 2'b00, 2'b00);
      chk_at(33, "norm_ar_ns",    S_AR_NS,   6'd0,  2'b00, 2'b00, 2'b00, 2'b00);
      chk_at(34, "norm_ew_go",    S_EW_GO,   6'd19, 2'b00, 2'b01, 2'b00, 2'b00);
      chk_at(53, "norm_ew_end",   S_EW_GO,   6'd0,  2'b00, 2'b01, 2'b00, 2'b00);
      chk_at(54, "norm_ew_left",  S_EW_LEFT, 6'd9,  2'b00, 2'b11, 2'b00, 2'b00);
      chk_at(64, "norm_ew_yel",   S_EW_YEL,  6'd1,  2'b00, 2'b10, 2'b00, 2'b00);
      chk_at(66, "norm_ar_ew",    S_AR_EW,   6'd0,  2'b00, 2'b00, 2'b00, 2'b00);
      chk_at(67, "norm_ns_again", S_NS_GO,   6'd19, 2'b01, 2'b00, 2'b00, 2'b00);

      // N/S pedestrian request pulsed at edge 5
      do_reset("reset_ped");
      chk_at(4, "ped_ns_go4", S_NS_GO, 6'd16, 2'b01, 2'b00, 2'b00, 2'b00);
      i_ped_req_ns = 1'b1;
      chk_at(5, "ped_press", S_NS_GO, 6'd15, 2'b01, 2'b00, 2'b00, 2'b00);
      i_ped_req_ns = 1'b0;
      chk_at(33, "ped_ar",    S_AR_NS, 6'd0,  2'b00, 2'b00, 2'b00, 2'b00);
      chk_at(34, "ped_walk0", S_EW_GO, 6'd19, 2'b00, 2'b01, 2'b01, 2'b00);
      chk_at(47, "ped_walk13", S_EW_GO, 6'd6, 2'b00, 2'b01, 2'b01, 2'b00);
      for (int k = 0; k < 6; k++)
         chk_at(48 + k, "ped_flash", S_EW_GO, 6'(5 - k), 2'b00, 2'b01,
                (k % 2 == 0) ? 2'b01 : 2'b00, 2'b00);
      chk_at(54,  "ped_left_off", S_EW_LEFT, 6'd9,  2'b00, 2'b11, 2'b00, 2'b00);
      chk_at(100, "ped_no_repeat", S_EW_GO,  6'd19, 2'b00, 2'b01, 2'b00, 2'b00);

      // Opposite-axis pre-emption from NS_GO
      do_reset("reset_emg_opp");
      chk_at(4, "opp_ns_go", S_NS_GO, 6'd16, 2'b01, 2'b00, 2'b00, 2'b00);
      i_emg = 1'b1; i_emg_dir = 1'b1;
      chk_at(5,  "opp_yel",    S_NS_YEL, 6'd1, 2'b10, 2'b00, 2'b00, 2'b00);
      chk_at(6,  "opp_yel2",   S_NS_YEL, 6'd0, 2'b10, 2'b00, 2'b00, 2'b00);
      chk_at(7,  "opp_ar",     S_AR_NS,  6'd0, 2'b00, 2'b00, 2'b00, 2'b00);
      chk_at(8,  "opp_pre",    S_PRE_EW, 6'd0, 2'b00, 2'b01, 2'b00, 2'b00);
      chk_at(10, "opp_pre_hold", S_PRE_EW, 6'd0, 2'b00, 2'b01, 2'b00, 2'b00);
      i_emg = 1'b0;
      chk_at(11, "opp_ew_yel", S_EW_YEL, 6'd1,  2'b00, 2'b10, 2'b00, 2'b00);
      chk_at(13, "opp_ar_ew",  S_AR_EW,  6'd0,  2'b00, 2'b00, 2'b00, 2'b00);
      chk_at(14, "opp_ns_go2", S_NS_GO,  6'd19, 2'b01, 2'b00, 2'b00, 2'b00);

      // Same-axis pre-emption during NS_LEFT with a pending N/S ped request
      do_reset("reset_emg_same");
      chk_at(2, "same_ns_go", S_NS_GO, 6'd18, 2'b01, 2'b00, 2'b00, 2'b00);
      i_ped_req_ns = 1'b1;
      chk_at(3, "same_press", S_NS_GO, 6'd17, 2'b01, 2'b00, 2'b00, 2'b00);
      i_ped_req_ns = 1'b0;
      chk_at(23, "same_left", S_NS_LEFT, 6'd7, 2'b11, 2'b00, 2'b00, 2'b00);
      i_emg = 1'b1; i_emg_dir = 1'b0;
      chk_at(24, "same_pre",      S_PRE_NS, 6'd0,  2'b01, 2'b00, 2'b00, 2'b00);
      chk_at(26, "same_pre_hold", S_PRE_NS, 6'd0,  2'b01, 2'b00, 2'b00, 2'b00);
      i_emg = 1'b0;
      chk_at(27, "same_yel",   S_NS_YEL, 6'd1,  2'b10, 2'b00, 2'b00, 2'b00);
      chk_at(29, "same_ar",    S_AR_NS,  6'd0,  2'b00, 2'b00, 2'b00, 2'b00);
      chk_at(30, "same_served", S_EW_GO, 6'd19, 2'b00, 2'b01, 2'b01, 2'b00);
      chk_at(43, "same_walk13", S_EW_GO, 6'd6,  2'b00, 2'b01, 2'b01, 2'b00);
      chk_at(44, "same_flash0", S_EW_GO, 6'd5,  2'b00, 2'b01, 2'b01, 2'b00);
      chk_at(45, "same_flash1", S_EW_GO, 6'd4,  2'b00, 2'b01, 2'b00, 2'b00);

      // Pause for 5 cycles mid-NS_GO, pressing E/W button while paused
      do_reset("reset_pause");
      chk_at(10, "pause_before", S_NS_GO, 6'd10, 2'b01, 2'b00, 2'b00, 2'b00);
      i_start = 1'b0;
      chk_at(11, "pause_hold1", S_NS_GO, 6'd10, 2'b01, 2'b00, 2'b00, 2'b00);
      i_ped_req_ew = 1'b1;
      chk_at(13, "pause_hold3", S_NS_GO, 6'd10, 2'b01, 2'b00, 2'b00, 2'b00);
      i_ped_req_ew = 1'b0;
      chk_at(15, "pause_hold5", S_NS_GO, 6'd10, 2'b01, 2'b00, 2'b00, 2'b00);
      i_start = 1'b1;
      chk_at(16, "pause_resume", S_NS_GO,  6'd9,  2'b01, 2'b00, 2'b00, 2'b00);
      chk_at(25, "pause_go_end", S_NS_GO,  6'd0,  2'b01, 2'b00, 2'b00, 2'b00);
      chk_at(26, "pause_left",   S_NS_LEFT, 6'd9, 2'b11, 2'b00, 2'b00, 2'b00);
      chk_at(39, "pause_ew_go",  S_EW_GO,  6'd19, 2'b00, 2'b01, 2'b00, 2'b00);
      chk_at(72, "pause_served", S_NS_GO,  6'd19, 2'b01, 2'b00, 2'b00, 2'b01);
      chk_at(85, "pause_walk13", S_NS_GO,  6'd6,  2'b01, 2'b00, 2'b00, 2'b01);
      chk_at(87, "pause_flash1", S_NS_GO,  6'd4,  2'b01, 2'b00, 2'b00, 2'b00);

      // Reset during EW_LEFT with both requests pending; glitch between edges
      do_reset("reset_mid");
      chk_at(39, "mid_ew_go", S_EW_GO, 6'd14, 2'b00, 2'b01, 2'b00, 2'b00);
      i_ped_req_ns = 1'b1; i_ped_req_ew = 1'b1;
      chk_at(40, "mid_press", S_EW_GO, 6'd13, 2'b00, 2'b01, 2'b00, 2'b00);
      i_ped_req_ns = 1'b0; i_ped_req_ew = 1'b0;
      chk_at(56, "mid_ew_left", S_EW_LEFT, 6'd7, 2'b00, 2'b11, 2'b00, 2'b00);
      rst_n = 1'b0;
      chk_at(57, "mid_reset", S_IDLE, 6'd0, 2'b00, 2'b00, 2'b00, 2'b00);
      rst_n = 1'b1;
      chk_at(58, "mid_restart", S_NS_GO, 6'd19, 2'b01, 2'b00, 2'b00, 2'b00);
      #1 rst_n = 1'b0;
      #2 rst_n = 1'b1;
      chk_at(59, "mid_glitch",  S_NS_GO, 6'd18, 2'b01, 2'b00, 2'b00, 2'b00);
      chk_at(91, "mid_pend_clr", S_EW_GO, 6'd19, 2'b00, 2'b01, 2'b00, 2'b00);

      step();
      step();
      n_chk++;
      if (q.size() != 0) begin
         n_err++;
         $display("FAIL drain: %0d expectations left unchecked, want 0", q.size());
      end
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
